mem_access_ctrl: RTL and testbench

Memory access controller that acts as the initiator for the 512×32 synchronous on-chip RAM. It sits between the CPU datapath/control unit and the RAM. It accepts single or burst read/write requests over a valid/ready handshake and sequences the RAM `read`/`write`/`address`/`data_in` pins. Read data from the RAM's one-cycle-latency `data_out` is returned to the requester with a valid strobe.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the RAM access controller: the controller state
// encoding, the default address/data/burst-length widths, and the depth
// of the 512 x 32 on-chip RAM the controller drives.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;
    localparam int MEM_WORDS  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator for a synchronous single-port RAM with one-cycle read latency.
// Accepts single or burst read/write requests over a valid/ready
// handshake and sequences the RAM read/write/address/data pins.
//
// Ports
//   clk, clr                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_write, req_addr, req_len  direction, start word, beats minus one
//   wr_data/wr_valid/wr_ready   write beat handshake
//   rd_data/rd_valid            read beat return
//   busy, done                  burst in progress, completion pulse
//   ram_read/ram_write/ram_addr/ram_wdata/ram_rdata  RAM pins
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic              rd_valid_q;

    // State, address, length and beat-count registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and combinational RAM/handshake outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = {LEN_W{1'b0}};
                    state_d = req_write ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // A read beat is issued every cycle; the address wraps
                // naturally at the top of the RAM.
                ram_read = 1'b1;
                ram_addr = addr_q;
                addr_d   = addr_q + ADDR_W'(1);
                cnt_d    = cnt_q + LEN_W'(1);
                if (cnt_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                // The requester paces the burst; a low wr_valid stalls it.
                wr_ready  = 1'b1;
                ram_write = wr_valid;
                ram_addr  = addr_q;
                ram_wdata = wr_data;
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data returns one cycle after the RAM read strobe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ram_read;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_rdata;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A behavioural RAM sits beside
// the controller; a reference memory image plus per-burst cycle
// expectations (derived from burst start/length and stall choices) give
// the expected values.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid, req_ready, req_write;
    logic [8:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, busy, done;
    logic        ram_read, ram_write;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [512];
    logic [31:0] wdat [16];

    // RAM model: preload port plus the controller's synchronous port.
    logic [31:0] ram [0:511];
    logic [31:0] ram_dout;
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else begin
            if (ram_write) ram[ram_addr] <= ram_wdata;
            if (ram_read)  ram_dout <= ram[ram_addr];
        end
    end
    assign ram_rdata = ram_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 32'd1);
        chk({tag, "_busy"},      busy,      32'd0);
        chk({tag, "_done"},      done,      32'd0);
        chk({tag, "_ram_read"},  ram_read,  32'd0);
        chk({tag, "_ram_write"}, ram_write, 32'd0);
        chk({tag, "_ram_addr"},  ram_addr,  32'd0);
        chk({tag, "_wr_ready"},  wr_ready,  32'd0);
        chk({tag, "_rd_valid"},  rd_valid,  32'd0);
    endtask

    // Read burst of l+1 beats from a; accepted in the current cycle.
    task automatic do_read(input logic [8:0] a, input logic [3:0] l, input bit hold);
        int n;
        n = int'(l) + 1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        wr_valid = 1'($urandom_range(0, 1));
        #1;
        chk("rd_req_ready0", req_ready, 32'd1);
        chk("rd_idle_nowrite", ram_write, 32'd0);
        for (int k = 1; k <= n; k++) begin
            cyc();
            if (!hold) req_valid = 1'b0;
            wr_valid = 1'($urandom_range(0, 1));
            #1;
            chk("rd_ram_read", ram_read, 32'd1);
            chk("rd_ram_write", ram_write, 32'd0);
            chk("rd_addr", ram_addr, 32'((int'(a) + k - 1) % 512));
            chk("rd_done_early", done, 32'd0);
            chk("rd_req_ready_busy", req_ready, 32'd0);
            chk("rd_valid", rd_valid, (k > 1) ? 32'd1 : 32'd0);
            if (k > 1) chk("rd_data", rd_data, ref_mem[(int'(a) + k - 2) % 512]);
        end
        cyc(); #1;
        chk("rd_done", done, 32'd1);
        chk("rd_last_valid", rd_valid, 32'd1);
        chk("rd_last_data", rd_data, ref_mem[(int'(a) + n - 1) % 512]);
        chk("rd_done_noread", ram_read, 32'd0);
        chk("rd_done_busy", busy, 32'd1);
        cyc(); #1;
        chk("rd_ready_again", req_ready, 32'd1);
        chk("rd_idle_busy", busy, 32'd0);
        chk("rd_idle_done", done, 32'd0);
        chk("rd_idle_valid", rd_valid, 32'd0);
    endtask

    // Write burst of l+1 beats from wdat[]; stall_len idle cycles before
    // beat stall_beat, optional random extra stalls.
    task automatic do_write(input logic [8:0] a, input logic [3:0] l,
                            input int stall_beat, input int stall_len, input bit rnd);
        int n, beat, stalled, cur, guard;
        logic wv;
        n = int'(l) + 1; beat = 0; stalled = 0; cur = int'(a); guard = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
        wr_valid = 1'b1; wr_data = 32'hBAD0BAD0;
        #1;
        chk("wr_req_ready0", req_ready, 32'd1);
        chk("wr_idle_nowrite", ram_write, 32'd0);
        chk("wr_idle_wr_ready", wr_ready, 32'd0);
        while (beat < n && guard < 200) begin
            cyc();
            guard++;
            req_valid = 1'b0;
            if (beat == stall_beat && stalled < stall_len) begin
                wv = 1'b0; stalled++;
            end else if (rnd) begin
                wv = ($urandom_range(0, 3) != 0);
            end else begin
                wv = 1'b1;
            end
            wr_valid = wv; wr_data = wdat[beat];
            #1;
            chk("wr_wr_ready", wr_ready, 32'd1);
            chk("wr_ram_write", ram_write, 32'(wv));
            chk("wr_ram_read", ram_read, 32'd0);
            chk("wr_done_early", done, 32'd0);
            if (wv) begin
                chk("wr_addr", ram_addr, 32'(cur));
                chk("wr_wdata", ram_wdata, wdat[beat]);
                ref_mem[cur] = wdat[beat];
                cur = (cur + 1) % 512;
                beat++;
            end
        end
        chk("wr_guard", 32'(guard < 200), 32'd1);
        cyc();
        wr_valid = 1'b1; wr_data = $urandom;
        #1;
        chk("wr_done", done, 32'd1);
        chk("wr_done_wr_ready", wr_ready, 32'd0);
        chk("wr_done_nowrite", ram_write, 32'd0);
        chk("wr_done_busy", busy, 32'd1);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("wr_ready_again", req_ready, 32'd1);
        chk("wr_idle_busy", busy, 32'd0);
        chk("wr_idle_done", done, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        logic [8:0] ra;
        logic [3:0] rl;
        clr = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 9'd0;
        req_len = 4'd0; wr_data = 32'd0; wr_valid = 1'b0;
        pl_en = 1'b0; pl_addr = 9'd0; pl_data = 32'd0;

        // Asynchronous reset mid-cycle, observed before any clock edge.
        #2 clr = 1'b1;
        #1;
        chk_reset_outputs("reset");

        // Preload RAM and reference image while held in reset.
        for (int i = 0; i < 512; i++) begin
            pl_en = 1'b1; pl_addr = 9'(i);
            pl_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = pl_data;
            cyc();
        end
        pl_en = 1'b0;
        cyc();
        clr = 1'b0;
        cyc();

        // Single read of the known word.
        chk("ref_deadbeef", ref_mem[5], 32'hDEADBEEF);
        do_read(9'h005, 4'd0, 1'b0);

        // Burst write wrapping the top of memory with a 2-cycle stall.
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        cyc();
        do_write(9'h1FE, 4'd3, 2, 2, 1'b0);
        cyc();
        chk("mem_1fe", ram[9'h1FE], 32'h11);
        chk("mem_1ff", ram[9'h1FF], 32'h22);
        chk("mem_000", ram[9'h000], 32'h33);
        chk("mem_001", ram[9'h001], 32'h44);

        // Burst read-back across the wrap.
        do_read(9'h1FE, 4'd3, 1'b0);

        // Request held during a 16-beat read: re-accepted at cycle 18.
        cyc();
        do_read(9'h0A0, 4'd15, 1'b1);
        do_read(9'h0A0, 4'd15, 1'b0);

        // Reset mid-read discards the pending rd_valid.
        cyc();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h020; req_len = 4'd3;
        cyc(); req_valid = 1'b0;
        cyc(); #1;
        chk("rrst_valid_before", rd_valid, 32'd1);
        clr = 1'b1;
        #1;
        chk_reset_outputs("rrst");
        cyc(); clr = 1'b0;
        cyc();

        // Reset after beat 2 of a 4-beat write to 0x010.
        for (int i = 0; i < 4; i++) wdat[i] = $urandom;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_len = 4'd3;
        cyc(); req_valid = 1'b0;
        wr_valid = 1'b1; wr_data = wdat[0]; ref_mem[16] = wdat[0];
        cyc(); wr_data = wdat[1]; ref_mem[17] = wdat[1];
        cyc(); wr_data = wdat[2];
        #1;
        chk("wrst_write_pending", ram_write, 32'd1);
        clr = 1'b1;
        #1;
        chk_reset_outputs("wrst");
        cyc(); clr = 1'b0; wr_valid = 1'b0;
        cyc(); #1;
        chk("wrst_idle", req_ready, 32'd1);
        for (int i = 16; i < 20; i++) chk("wrst_mem", ram[i], ref_mem[i]);

        // Randomized bursts against the reference image.
        for (int t = 0; t < 10; t++) begin
            ra = 9'($urandom_range(0, 511));
            rl = 4'($urandom_range(0, 15));
            cyc();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wdat[i] = $urandom;
                do_write(ra, rl, int'($urandom_range(0, int'(rl))), int'($urandom_range(0, 3)), 1'b1);
            end else begin
                do_read(ra, rl, 1'b0);
            end
        end

        // Whole-memory comparison with the reference image.
        cyc();
        mism = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("memcmp", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
